vector_item_sequencer: RTL

Streams the elements of a packed vector operand out one at a time, in index order, over a valid/ready handshake. It latches a whole vector on `start`, drives the element address into an internal `VectorItemExtractor` instance, and presents each selected item to a downstream scalar consumer (lane ALU, store unit). It is the sequencing front end for any vector instruction that processes elements serially.

---
 rtl/vector_item_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/vector_item_sequencer.sv
// rtl/vector_item_sequencer.sv - serial element streamer for packed vector operands
//
// VectorItemExtractor: combinational element select.
//   vec_i   [N-1:0][W-1:0]  source vector
//   addr_i  [AW-1:0]        element address (out-of-range selects 0)
//   item_o  [W-1:0]         selected element
//
// vector_item_sequencer: latches a vector on start and streams its
// elements in index order over a valid/ready handshake.
//   clk, rst            clock, async active-high reset
//   start               begin a sequence (sampled in IDLE only)
//   vector_in, count    operand and element count (0 or >N means N)
//   item_ready          downstream accepts current item
//   item_valid          item/item_index valid
//   item, item_index    current element and its address
//   busy                high in STREAM and DONE
//   done                one-cycle end-of-sequence pulse

module VectorItemExtractor #(
  parameter int N  = 20,
  parameter int W  = 10,
  parameter int AW = 5
) (
  input  logic [N-1:0][W-1:0] vec_i,
  input  logic [AW-1:0]       addr_i,
  output logic [W-1:0]        item_o
);

  always_comb begin
    item_o = '0;
    for (int i = 0; i < N; i++) begin
      if (addr_i == AW'(i)) item_o = vec_i[i];
    end
  end

endmodule

module vector_item_sequencer #(
  parameter int N  = 20,
  parameter int W  = 10,
  parameter int AW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0][W-1:0] vector_in,
  input  logic [AW-1:0]       count,
  input  logic                item_ready,
  output logic                item_valid,
  output logic [W-1:0]        item,
  output logic [AW-1:0]       item_index,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [AW-1:0] N_CNT = AW'(N);

  state_e               state_q;
  logic [N-1:0][W-1:0]  vec_q;
  logic [AW-1:0]        last_q;
  logic [AW-1:0]        addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vec_q  <= vector_in;
            // Zero and oversize counts both mean "whole vector".
            if (count == '0 || count > N_CNT) last_q <= N_CNT - AW'(1);
            else                              last_q <= count - AW'(1);
            addr_q  <= '0;
            state_q <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (item_ready) begin
            // Address holds on the final element so it never passes last_q.
            if (addr_q == last_q) state_q <= S_DONE;
            else                  addr_q  <= addr_q + AW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign item_valid = (state_q == S_STREAM);
  assign busy       = (state_q == S_STREAM) || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign item_index = addr_q;

  VectorItemExtractor #(.N(N), .W(W), .AW(AW)) u_extract (
    .vec_i  (vec_q),
    .addr_i (addr_q),
    .item_o (item)
  );

endmodule
